// File: rtl/counter_pkg.sv
// +----------------------------------------------------------------------+
// | counter_pkg: mode encodings and step-result flags for mod_counter    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package counter_pkg;

   localparam logic [1:0] MODE_WRAP     = 2'b00;
   localparam logic [1:0] MODE_SAT      = 2'b01;
   localparam logic [1:0] MODE_ONESHOT  = 2'b10;
   localparam logic [1:0] MODE_WRAP_ALT = 2'b11;

   // Side effects of one enabled step, as computed by mod_counter_next.
   typedef struct packed {
      logic moved;     // count left its current value (normal step or wrap)
      logic wrap;      // step wrapped to the opposite end
      logic sat_hold;  // saturate mode held at the bound
      logic done_hit;  // one-shot mode reached (or sits at) the bound
   } step_flags_t;

   function automatic logic is_wrap_mode(input logic [1:0] m);
      return (m == MODE_WRAP) || (m == MODE_WRAP_ALT);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mod_counter_next.sv
// +----------------------------------------------------------------------+
// | mod_counter_next: combinational next-count and step flags            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mod_counter_next
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2 ** WIDTH
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] next_count,
   output logic             terminal,
   output step_flags_t      flags
);

   localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] c_zero = '0;
   localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

   logic [WIDTH-1:0] w_bound;
   logic             w_at_bound;

   assign w_bound    = up ? c_max : c_zero;
   assign w_at_bound = (count == w_bound);
   assign terminal   = w_at_bound;

   always_comb begin
      next_count = count;
      flags      = '0;
      if (!w_at_bound) begin
         next_count     = up ? (count + c_one) : (count - c_one);
         flags.moved    = 1'b1;
         flags.done_hit = (mode == MODE_ONESHOT) && (next_count == w_bound);
      end else if (is_wrap_mode(mode)) begin
         next_count  = up ? c_zero : c_max;
         flags.moved = 1'b1;
         flags.wrap  = 1'b1;
      end else if (mode == MODE_SAT) begin
         flags.sat_hold = 1'b1;
      end else begin
         // One-shot sitting at the bound (e.g. loaded there) counts as reached.
         flags.done_hit = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// +----------------------------------------------------------------------+
// | mod_counter: modulus up/down counter with wrap/saturate/one-shot     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2 ** WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] count,
   output logic             terminal,
   output logic             wrap_pulse,
   output logic             saturated,
   output logic             done
);

   localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

   generate
      if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
         $error("mod_counter: MODULUS must lie in 2..2**WIDTH");
      end
   endgenerate

   logic [WIDTH-1:0] r_count;
   logic             r_wrap_pulse;
   logic             r_saturated;
   logic             r_done;

   logic [WIDTH-1:0] w_next_count;
   logic [WIDTH-1:0] w_load_value;
   logic             w_step;
   step_flags_t      w_flags;

   mod_counter_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .count      (r_count),
      .up         (up),
      .mode       (mode),
      .next_count (w_next_count),
      .terminal   (terminal),
      .flags      (w_flags)
   );

   assign w_load_value = (load_value > c_max) ? c_max : load_value;
   // A finished one-shot ignores enable until clear, load or reset.
   assign w_step       = enable && !((mode == MODE_ONESHOT) && r_done);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count      <= '0;
         r_wrap_pulse <= 1'b0;
         r_saturated  <= 1'b0;
         r_done       <= 1'b0;
      end else if (clear) begin
         r_count      <= '0;
         r_wrap_pulse <= 1'b0;
         r_saturated  <= 1'b0;
         r_done       <= 1'b0;
      end else if (load) begin
         r_count      <= w_load_value;
         r_wrap_pulse <= 1'b0;
         r_saturated  <= 1'b0;
         r_done       <= 1'b0;
      end else if (w_step) begin
         r_count      <= w_next_count;
         r_wrap_pulse <= w_flags.wrap;
         if (w_flags.sat_hold) begin
            r_saturated <= 1'b1;
         end else if (w_flags.moved) begin
            r_saturated <= 1'b0;
         end
         if (w_flags.done_hit) begin
            r_done <= 1'b1;
         end
      end else begin
         r_wrap_pulse <= 1'b0;
      end
   end

   assign count      = r_count;
   assign wrap_pulse = r_wrap_pulse;
   assign saturated  = r_saturated;
   assign done       = r_done;

endmodule

`default_nettype wire
